// File: rtl/adder_operand_controller.sv
// adder_operand_controller
// Sequential front end for a WIDTH-bit combinational adder. Holds the
// accumulator (A) and operand (B) registers that drive the adder inputs.
// A rising edge on Run holds both operands stable for SETTLE_CYCLES clocks.
// It then captures the adder Sum/CO back into A and CO_reg.
module adder_operand_controller #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic             Run,
    input  logic [WIDTH-1:0] Sum,
    input  logic             CO,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             CO_reg,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Counter preload: SETTLE_CYCLES-1 so that the capture lands exactly
    // SETTLE_CYCLES edges after the start edge (legal range 1..15).
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic             run_prev_reg;
    logic             run_armed_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             co_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             start;

    // A start needs a fresh press: Run must have been seen low since reset,
    // so a button still held through a reset cannot trigger an add.
    assign start = Run && !run_prev_reg && run_armed_reg;

    // Control FSM with the operand/result registers; every output is registered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            run_prev_reg  <= 1'b0;
            run_armed_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            co_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            run_prev_reg <= Run;
            if (!Run) begin
                run_armed_reg <= 1'b1;
            end
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (LoadB) begin
                        b_reg <= SW;
                    end
                    if (ClearA) begin
                        a_reg  <= '0;
                        co_reg <= 1'b0;
                    end
                    if (start) begin
                        state_reg <= SETTLE;
                        cnt_reg   <= CNT_INIT;
                        busy_reg  <= 1'b1;
                    end
                end

                SETTLE: begin
                    // Operands stay frozen here so the adder output can settle.
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        a_reg     <= Sum;
                        co_reg    <= CO;
                        done_reg  <= 1'b1;
                        state_reg <= HOLD;
                    end
                end

                HOLD: begin
                    // Wait for the button release so one press gives one add.
                    if (!Run) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign A      = a_reg;
    assign B      = b_reg;
    assign CO_reg = co_reg;
    assign Busy   = busy_reg;
    assign Done   = done_reg;

endmodule

// File: tb/tb_adder_operand_controller.sv
// tb_adder_operand_controller
// Directed bench for adder_operand_controller with a behavioural adder attached.
// The stimulus pushes each expected capture (A, CO_reg, Done cycle) into a queue.
// A monitor pops and compares an entry on every Done pulse.
module tb_adder_operand_controller;

    localparam int W      = 16;
    localparam int SETTLE = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] SW;
    logic         LoadB;
    logic         ClearA;
    logic         Run;
    logic [W-1:0] Sum;
    logic         CO;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CO_reg;
    logic         Busy;
    logic         Done;

    logic [W:0]   add_full;

    typedef struct {
        logic [W-1:0] a;
        logic         co;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    adder_operand_controller #(
        .WIDTH        (W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .SW    (SW),
        .LoadB (LoadB),
        .ClearA(ClearA),
        .Run   (Run),
        .Sum   (Sum),
        .CO    (CO),
        .A     (A),
        .B     (B),
        .CO_reg(CO_reg),
        .Busy  (Busy),
        .Done  (Done)
    );

    // Behavioural combinational adder standing in for the lab adders.
    assign add_full = {1'b0, A} + {1'b0, B};
    assign Sum      = add_full[W-1:0];
    assign CO       = add_full[W];

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no Done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("capture_A", 32'(A), 32'(e.a));
                chk("capture_CO", 32'(CO_reg), 32'(e.co));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(Busy), 32'd1);
                $display("[TB] capture cycle %0d: A=%h CO=%b (expected A=%h CO=%b)",
                         cyc, A, CO_reg, e.a, e.co);
            end
        end
    end

    // Advance one clock; inputs change and checks happen 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Queue the expected capture for a start sampled at the next edge.
    task automatic expect_add(input logic [W-1:0] a, input logic co);
        exp_t e;
        e.a   = a;
        e.co  = co;
        e.cyc = cyc + 1 + SETTLE;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until every queued capture has been seen.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d captures pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Press Run, expect one capture, keep Run held for extra cycles, then release.
    task automatic do_add(input string name, input logic [W-1:0] a, input logic co, input int hold);
        Run = 1'b1;
        expect_add(a, co);
        tick();
        chk({name, "_busy_start"}, 32'(Busy), 32'd1);
        wait_drain(name);
        repeat (hold) tick();
        chk({name, "_busy_held"}, 32'(Busy), 32'd1);
        Run = 1'b0;
        tick();
        chk({name, "_busy_clear"}, 32'(Busy), 32'd0);
        tick();
    endtask

    initial begin
        Reset  = 1'b1;
        SW     = '0;
        LoadB  = 1'b0;
        ClearA = 1'b0;
        Run    = 1'b0;
        tick();
        tick();
        chk("reset_A", 32'(A), 32'h0);
        chk("reset_B", 32'(B), 32'h0);
        chk("reset_CO", 32'(CO_reg), 32'h0);
        chk("reset_busy", 32'(Busy), 32'h0);
        chk("reset_done", 32'(Done), 32'h0);
        Reset = 1'b0;
        tick();

        // 1: load B=5, one add from A=0
        SW = 16'h0005; LoadB = 1'b1; tick(); LoadB = 1'b0;
        chk("loadb_5", 32'(B), 32'h0005);
        do_add("t1", 16'h0005, 1'b0, 3);

        // 2: accumulate
        do_add("t2", 16'h000A, 1'b0, 1);
        chk("t2_B_kept", 32'(B), 32'h0005);

        // 3: overflow
        SW = 16'hFFFF; LoadB = 1'b1; ClearA = 1'b1; tick(); LoadB = 1'b0; ClearA = 1'b0;
        chk("t3_clearA", 32'(A), 32'h0);
        do_add("t3a", 16'hFFFF, 1'b0, 0);
        SW = 16'h0001; LoadB = 1'b1; tick(); LoadB = 1'b0;
        do_add("t3b", 16'h0000, 1'b1, 0);
        repeat (3) tick();
        chk("t3_CO_persist", 32'(CO_reg), 32'h1);
        ClearA = 1'b1; tick(); ClearA = 1'b0;
        chk("t3_clear_A", 32'(A), 32'h0);
        chk("t3_clear_CO", 32'(CO_reg), 32'h0);

        // 4: long hold gives exactly one add, then a second press adds again
        SW = 16'h0002; LoadB = 1'b1; tick(); LoadB = 1'b0;
        do_add("t4a", 16'h0002, 1'b0, 20);
        do_add("t4b", 16'h0004, 1'b0, 0);

        // 5: LoadB/ClearA ignored in SETTLE and HOLD
        SW = 16'h0003; LoadB = 1'b1; tick(); LoadB = 1'b0;
        Run = 1'b1;
        expect_add(16'h0007, 1'b0);
        tick();
        SW = 16'h1234; LoadB = 1'b1; ClearA = 1'b1;
        tick(); tick();
        LoadB = 1'b0; ClearA = 1'b0;
        wait_drain("t5");
        chk("t5_B_frozen", 32'(B), 32'h0003);
        SW = 16'hBEEF; LoadB = 1'b1; ClearA = 1'b1; tick(); LoadB = 1'b0; ClearA = 1'b0;
        chk("t5_hold_B", 32'(B), 32'h0003);
        chk("t5_hold_A", 32'(A), 32'h0007);
        Run = 1'b0; tick(); tick();
        chk("t5_busy_clear", 32'(Busy), 32'h0);

        // 5b: LoadB, ClearA and start on the same edge -> add uses A=0, new B
        SW = 16'h0010; LoadB = 1'b1; ClearA = 1'b1; Run = 1'b1;
        expect_add(16'h0010, 1'b0);
        tick();
        LoadB = 1'b0; ClearA = 1'b0;
        wait_drain("t5b");
        Run = 1'b0; tick(); tick();

        // 6: reset during SETTLE with Run held
        Run = 1'b1;
        tick(); tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("t6_A", 32'(A), 32'h0);
        chk("t6_B", 32'(B), 32'h0);
        chk("t6_busy", 32'(Busy), 32'h0);
        chk("t6_done", 32'(Done), 32'h0);
        repeat (10) tick();
        chk("t6_no_add_busy", 32'(Busy), 32'h0);
        chk("t6_no_add_A", 32'(A), 32'h0);
        Run = 1'b0; tick();
        SW = 16'h0007; LoadB = 1'b1; tick(); LoadB = 1'b0;
        do_add("t6", 16'h0007, 1'b0, 0);

        repeat (5) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
